pipelined_adder: RTL

//   Parametrised, pipelined successor to the 4-bit ripple-carry adder:

---
 rtl/pipelined_adder_if.sv | 24 ++
 rtl/pipelined_adder.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder: valid/ready in, valid/ready out.
interface pipelined_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained slices, one register stage per slice.
// Whole pipeline advances together on en = !out_valid | out_ready.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int SW = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0 || SW < 1) begin : g_param_err
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] bx;
  logic             c0;

  // Subtract is A + ~B + 1, so the inversion and forced carry happen before slicing.
  assign bx          = bus.sub ? ~bus.b : bus.b;
  assign c0          = bus.sub | bus.cin;
  assign en          = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int HI = (k + 1) * SW;

    logic          vld_q;
    logic          vld_d;
    logic [HI-1:0] s_q;
    logic [HI-1:0] s_d;
    logic [SW-1:0] a_sl;
    logic [SW-1:0] b_sl;
    logic          ci;
    logic [SW:0]   add;

    assign add = {1'b0, a_sl} + {1'b0, b_sl} + {{SW{1'b0}}, ci};

    if (k == 0) begin : g_src
      assign a_sl  = bus.a[SW-1:0];
      assign b_sl  = bx[SW-1:0];
      assign ci    = c0;
      assign vld_d = bus.in_valid;
      assign s_d   = add[SW-1:0];
    end else begin : g_src
      assign a_sl  = g_st[k-1].g_mid.a_q[SW-1:0];
      assign b_sl  = g_st[k-1].g_mid.b_q[SW-1:0];
      assign ci    = g_st[k-1].g_mid.c_q;
      assign vld_d = g_st[k-1].vld_q;
      assign s_d   = {add[SW-1:0], g_st[k-1].s_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
      end else if (en) begin
        vld_q <= vld_d;
        s_q   <= s_d;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      // Operand bits not yet consumed ride along with the beat.
      logic [WIDTH-HI-1:0] a_q;
      logic [WIDTH-HI-1:0] b_q;
      logic                c_q;
      logic [WIDTH-HI-1:0] a_up;
      logic [WIDTH-HI-1:0] b_up;

      if (k == 0) begin : g_up
        assign a_up = bus.a[WIDTH-1:SW];
        assign b_up = bx[WIDTH-1:SW];
      end else begin : g_up
        assign a_up = g_st[k-1].g_mid.a_q[WIDTH-LO-1:SW];
        assign b_up = g_st[k-1].g_mid.b_q[WIDTH-LO-1:SW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (en) begin
          a_q <= a_up;
          b_q <= b_up;
          c_q <= add[SW];
        end
      end
    end else begin : g_last
      logic cout_q;
      logic ovf_q;

      // Carry into the MSB is recovered from the MSB's own sum bit: a ^ b ^ s.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (en) begin
          cout_q <= add[SW];
          ovf_q  <= add[SW] ^ (a_sl[SW-1] ^ b_sl[SW-1] ^ add[SW-1]);
        end
      end

      assign bus.out_valid = vld_q;
      assign bus.sum       = s_q;
      assign bus.cout      = cout_q;
      assign bus.ovf       = ovf_q;
    end
  end
endmodule
